sar_adc_ctrl: RTL
=================

// Module: sar_adc_ctrl
// PURPOSE
//  Successive-approximation ADC controller: the readback path of the 10-bit DAC.
//  It drives a trial code into the DAC and samples an external comparator
//  (cmp_in=1 means Vin >= Vdac), resolving one bit per step from MSB to LSB.
//  It returns a WIDTH-bit parallel result with a one-cycle done strobe.
// PARAMETERS
//  WIDTH          10  resolution; equals the DAC width; legal range >= 2
//  SETTLE_CYCLES   4  clocks the DAC/comparator settle before each decision; >= 1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request a conversion; honoured only in IDLE
//  cmp_in     in   1      comparator output; 1 = Vin >= Vdac
//  dac_code   out  WIDTH  trial code driven to the DAC input
//  busy       out  1      high in SETTLE/DECIDE/DONE
//  done       out  1      one-cycle pulse; result is valid in this cycle
//  result     out  WIDTH  last completed conversion; held until next done
// BEHAVIOUR
//  Reset: state=IDLE; dac_code=0, busy=0, done=0, result=0, bit_idx=WIDTH-1, cnt=0.
//   Reset applied mid-conversion aborts it at that edge; no done pulse follows.
//  IDLE: dac_code holds its last value. When start=1: dac_code <= 1<<(WIDTH-1),
//   bit_idx <= WIDTH-1, cnt <= 0, state <= SETTLE.
//  SETTLE: cnt += 1 each clock. When cnt==SETTLE_CYCLES-1: state <= DECIDE.
//   SETTLE therefore lasts SETTLE_CYCLES cycles.
//  DECIDE (1 cycle): if cmp_in==0, clear dac_code[bit_idx]. If bit_idx==0: DONE.
//   Otherwise set dac_code[bit_idx-1], bit_idx -= 1, cnt <= 0, state <= SETTLE.
//  DONE (1 cycle): done=1, result=dac_code. Next state is IDLE. start is ignored.
//  start while busy is ignored; it is not queued.
//   Holding start high gives back-to-back conversions, one per IDLE visit.
//  Latency: done is high WIDTH*(SETTLE_CYCLES+1) cycles after the edge that
//   sampled start. Default is 50. A new start is accepted every 52 cycles max.
//  cmp_in is sampled only in DECIDE; its value in other states is don't-care.
//  Arithmetic: pure bit set/clear; no carries. dac_code never exceeds 2^WIDTH-1.
//  All outputs are registered; no combinational path from an input to an output.
// CONFIGURATION
//  CMP_SYNC_EN defined: cmp_in passes through a 2-flop synchroniser (reset to 0).
//   The SETTLE exit compare becomes cnt==SETTLE_CYCLES+1, so SETTLE lasts
//   SETTLE_CYCLES+2 cycles. Latency becomes WIDTH*(SETTLE_CYCLES+3); default 70.
//  CMP_SYNC_EN undefined: cmp_in is sampled directly in DECIDE. It must be
//   synchronous to clk.
// STRUCTURE
//  sar_adc_pkg holds the state enum (IDLE, SETTLE, DECIDE, DONE), the default
//   ADC_WIDTH=10 (shared with the DAC), and the default ADC_SETTLE=4.
//  Sub-module cmp_sync is the 2-flop synchroniser. It is instantiated only
//   under CMP_SYNC_EN.
//  The counter width is $clog2(SETTLE_CYCLES+2).
// TESTING
//  Reset: hold rst 3 cycles -> all outputs 0, busy=0, and no done pulse.
//  Ideal comparator model (cmp_in = Vin>=dac_code), Vin=0x2A5 -> trial codes
//   0x200, 0x300, 0x280, ...; done at cycle 50; result=0x2A5.
//  cmp_in stuck 0 -> result=0x000. cmp_in stuck 1 -> result=0x3FF.
//   Both complete in 50 cycles.
//  start pulses at cycles 5 and 30 after a start at 0 -> single done at 50;
//   result unaffected.
//  rst at cycle 20 of a conversion -> IDLE next cycle, dac_code=0, result=0,
//   no done. A fresh start then completes normally.
//  With CMP_SYNC_EN, Vin=0x155 -> result=0x155 and done at cycle 70.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// -----------------------------------------------------------------------------
// sar_adc_pkg
//   Shared definitions for the successive-approximation ADC controller.
//   ADC_WIDTH is the common resolution of the ADC readback path and the DAC
//   it drives; ADC_SETTLE is the default DAC/comparator settling time in clocks.
//   Optional build macro used by the controller: CMP_SYNC_EN.
// -----------------------------------------------------------------------------
package sar_adc_pkg;

   localparam int ADC_WIDTH  = 10;
   localparam int ADC_SETTLE = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } sar_state_e;

   // Number of clocks one bit trial takes (settle window plus the decide cycle).
   function automatic int bit_period(input int settle_cycles, input bit synced);
      if (synced) begin
         return settle_cycles + 3;
      end else begin
         return settle_cycles + 1;
      end
   endfunction

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// -----------------------------------------------------------------------------
// cmp_sync
//   Two-flop synchroniser for the asynchronous comparator output.
//   Only compiled when CMP_SYNC_EN is defined; the default build samples the
//   comparator directly and needs no synchroniser.
//   Ports:
//     clk  in  1  system clock, rising edge
//     rst  in  1  synchronous, active-high reset (flops clear to 0)
//     d    in  1  asynchronous input
//     q    out 1  input resynchronised to clk
// -----------------------------------------------------------------------------
`ifdef CMP_SYNC_EN
module cmp_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_r;

   // Two-stage shift register; meta_r may go metastable, q gets a full cycle to resolve it.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule
`endif

// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation ADC controller. Drives a trial code into the DAC,
//   waits for the DAC/comparator to settle, and resolves one bit per trial from
//   MSB to LSB using the comparator (cmp_in=1 means Vin >= Vdac).
//   Build macro: CMP_SYNC_EN -- route cmp_in through a 2-flop synchroniser and
//   stretch each settle window by two clocks to cover its latency.
//   Parameters:
//     WIDTH          resolution, equal to the DAC width (>= 2)
//     SETTLE_CYCLES  settling clocks before each decision (>= 1)
//   Ports:
//     clk       in   1      system clock, rising edge
//     rst       in   1      synchronous, active-high reset
//     start     in   1      conversion request, honoured only when idle
//     cmp_in    in   1      comparator output
//     dac_code  out  WIDTH  trial code to the DAC
//     busy      out  1      conversion in progress (settle/decide/done)
//     done      out  1      one-cycle strobe, result valid in this cycle
//     result    out  WIDTH  last completed conversion, held until next done
// -----------------------------------------------------------------------------
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int WIDTH         = ADC_WIDTH,
   parameter int SETTLE_CYCLES = ADC_SETTLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
   localparam int IDX_W = $clog2(WIDTH);

   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE_HOT = WIDTH'(1);

   sar_state_e         state_r;
   logic [IDX_W-1:0]   bit_idx_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               cmp_s;
   logic [WIDTH-1:0]   bit_mask_s;
   logic [WIDTH-1:0]   decided_code_s;
   logic [WIDTH-1:0]   next_trial_s;

`ifdef CMP_SYNC_EN
   // Synchroniser adds two clocks of delay, so the settle window grows by two.
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + 1);

   cmp_sync u_cmp_sync (
      .clk (clk),
      .rst (rst),
      .d   (cmp_in),
      .q   (cmp_s)
   );
`else
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   assign cmp_s = cmp_in;
`endif

   // Decision arithmetic: clear the bit under trial if Vin is below Vdac, then
   // raise the next lower bit as the following trial. Pure bit set/clear.
   always_comb begin
      bit_mask_s     = ONE_HOT << bit_idx_r;
      decided_code_s = dac_code;
      if (cmp_s) begin
         decided_code_s = dac_code;
      end else begin
         decided_code_s = dac_code & ~bit_mask_s;
      end
      next_trial_s   = decided_code_s | (bit_mask_s >> 1);
   end

   // Conversion sequencer: state, bit index, settle counter and all outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         dac_code  <= {WIDTH{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= {WIDTH{1'b0}};
         bit_idx_r <= IDX_MSB;
         cnt_r     <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dac_code  <= ONE_HOT << IDX_MSB;
                  bit_idx_r <= IDX_MSB;
                  cnt_r     <= {CNT_W{1'b0}};
                  busy      <= 1'b1;
                  state_r   <= ST_SETTLE;
               end else begin
                  busy      <= 1'b0;
               end
            end

            ST_SETTLE: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == SETTLE_LAST) begin
                  state_r <= ST_DECIDE;
               end else begin
                  state_r <= ST_SETTLE;
               end
            end

            ST_DECIDE: begin
               if (bit_idx_r == {IDX_W{1'b0}}) begin
                  dac_code <= decided_code_s;
                  result   <= decided_code_s;
                  done     <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  dac_code  <= next_trial_s;
                  bit_idx_r <= bit_idx_r - IDX_W'(1);
                  cnt_r     <= {CNT_W{1'b0}};
                  state_r   <= ST_SETTLE;
               end
            end

            ST_DONE: begin
               // start is deliberately ignored here; it is seen next cycle in IDLE.
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end

            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
